// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the fetch PC, issues one outstanding imem
// request at a time and buffers one instruction for decode.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_take_branch_in,
    input  logic [31:0] ex_target_PC_in,
    input  logic        id_stall_in,
    input  logic        Imem2proc_valid,
    input  logic [31:0] Imem2proc_data,
    output logic        proc2Imem_req,
    output logic [31:0] proc2Imem_addr,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_IR_out,
    output logic        if_valid_inst_out
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic        buf_valid_q, buf_valid_d;
    logic        consume;
    logic        req;
    logic        fill;

    always_comb begin
        consume = buf_valid_q & ~id_stall_in;
        req     = (state_q == S_REQ) & ~ex_take_branch_in
                  & (~buf_valid_q | consume);
        fill    = (state_q == S_WAIT) & Imem2proc_valid
                  & ~ex_take_branch_in;

        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        buf_valid_d = buf_valid_q;

        if (ex_take_branch_in) begin
            // Redirect beats stall, fill and request; a response landing
            // this same cycle is the stale one, so no flush wait is needed.
            fetch_pc_d  = {ex_target_PC_in[31:2], 2'b00};
            buf_valid_d = 1'b0;
            ir_d        = NOP_INST;
            case (state_q)
                S_REQ:   state_d = S_REQ;
                S_WAIT,
                S_FLUSH: state_d = Imem2proc_valid ? S_REQ : S_FLUSH;
                default: state_d = S_REQ;
            endcase
        end else begin
            if (consume) begin
                buf_valid_d = 1'b0;
                ir_d        = NOP_INST;
            end
            if (fill) begin
                buf_valid_d = 1'b1;
                ir_d        = Imem2proc_data;
                pc_d        = fetch_pc_q;
                npc_d       = fetch_pc_q + 32'd4;
                fetch_pc_d  = fetch_pc_q + 32'd4;
            end
            case (state_q)
                S_REQ:   state_d = req ? S_WAIT : S_REQ;
                S_WAIT:  state_d = Imem2proc_valid ? S_REQ : S_WAIT;
                S_FLUSH: state_d = Imem2proc_valid ? S_REQ : S_FLUSH;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            ir_q        <= NOP_INST;
            pc_q        <= RESET_PC;
            npc_q       <= RESET_PC + 32'd4;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign proc2Imem_req     = req & ~rst;
    assign proc2Imem_addr    = fetch_pc_q;
    assign if_PC_out         = pc_q;
    assign if_NPC_out        = npc_q;
    assign if_IR_out         = ir_q;
    assign if_valid_inst_out = buf_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, streaming, stall, redirects,
// reset during an outstanding request and PC wrap.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        take;
    logic [31:0] target;
    logic        stall;
    logic        mvalid;
    logic [31:0] mdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
    logic        vld;

    int tests;
    int failed;

    if_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_take_branch_in (take),
        .ex_target_PC_in   (target),
        .id_stall_in       (stall),
        .Imem2proc_valid   (mvalid),
        .Imem2proc_data    (mdata),
        .proc2Imem_req     (req),
        .proc2Imem_addr    (addr),
        .if_PC_out         (pc),
        .if_NPC_out        (npc),
        .if_IR_out         (ir),
        .if_valid_inst_out (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue-and-return for one word with a 1-cycle memory, no stall.
    task automatic fetch_word(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] n;
        n = a + 32'd4;
        #1;
        chk("fw_req", {31'd0, req}, 32'd1);
        chk("fw_addr", addr, a);
        tick();
        mvalid = 1'b1;
        mdata  = d;
        #1;
        chk("fw_wait_req", {31'd0, req}, 32'd0);
        chk("fw_wait_vld", {31'd0, vld}, 32'd0);
        tick();
        mvalid = 1'b0;
        mdata  = 32'hxxxx_xxxx;
        #1;
        chk("fw_vld", {31'd0, vld}, 32'd1);
        chk("fw_pc", pc, a);
        chk("fw_npc", npc, n);
        chk("fw_ir", ir, d);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        take   = 1'b0;
        target = 32'd0;
        stall  = 1'b0;
        mvalid = 1'b0;
        mdata  = 32'd0;

        // Reset state
        tick();
        #1;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_vld", {31'd0, vld}, 32'd0);
        chk("rst_ir", ir, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_npc", npc, 32'h4);
        rst = 1'b0;

        // Straight-line fetch
        fetch_word(32'h0, 32'h00A0_0093);
        fetch_word(32'h4, 32'h0010_0113);
        fetch_word(32'h8, 32'h0020_0193);

        // Stall holds the buffered instruction for three cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stl_req", {31'd0, req}, 32'd0);
            chk("stl_vld", {31'd0, vld}, 32'd1);
            chk("stl_pc", pc, 32'h8);
            chk("stl_ir", ir, 32'h0020_0193);
            tick();
        end
        stall = 1'b0;
        fetch_word(32'hC, 32'h0030_0213);

        // Redirect while waiting; stale response two cycles later
        #1;
        chk("rw_req", {31'd0, req}, 32'd1);
        chk("rw_addr", addr, 32'h10);
        tick();
        take   = 1'b1;
        target = 32'h0000_0107;
        #1;
        chk("rw_req0", {31'd0, req}, 32'd0);
        tick();
        take = 1'b0;
        #1;
        chk("rw_vld", {31'd0, vld}, 32'd0);
        chk("rw_ir", ir, NOP);
        chk("rw_flush_req", {31'd0, req}, 32'd0);
        tick();
        mvalid = 1'b1;
        mdata  = 32'hDEAD_BEEF;
        #1;
        chk("rw_flush_req2", {31'd0, req}, 32'd0);
        tick();
        mvalid = 1'b0;
        #1;
        chk("rw_stale_vld", {31'd0, vld}, 32'd0);
        chk("rw_stale_ir", ir, NOP);
        fetch_word(32'h104, 32'h0000_0533);

        // Redirect coinciding with a response
        tick();
        mvalid = 1'b1;
        mdata  = 32'h1111_1111;
        take   = 1'b1;
        target = 32'h0000_0200;
        #1;
        chk("rr_req0", {31'd0, req}, 32'd0);
        tick();
        mvalid = 1'b0;
        take   = 1'b0;
        #1;
        chk("rr_vld", {31'd0, vld}, 32'd0);
        chk("rr_ir", ir, NOP);
        fetch_word(32'h200, 32'h0050_0593);

        // Redirect while the buffer is valid and decode stalled
        stall  = 1'b1;
        take   = 1'b1;
        target = 32'h0000_0300;
        #1;
        chk("rs_req0", {31'd0, req}, 32'd0);
        tick();
        take = 1'b0;
        #1;
        chk("rs_vld", {31'd0, vld}, 32'd0);
        chk("rs_ir", ir, NOP);
        stall = 1'b0;
        fetch_word(32'h300, 32'h0060_0613);

        // Reset during an outstanding request
        tick();
        rst = 1'b1;
        #1;
        chk("rm_req_rst", {31'd0, req}, 32'd0);
        tick();
        rst    = 1'b0;
        mvalid = 1'b1;
        mdata  = 32'h0BAD_0BAD;
        #1;
        chk("rm_vld", {31'd0, vld}, 32'd0);
        chk("rm_ir", ir, NOP);
        chk("rm_pc", pc, 32'h0);
        chk("rm_req", {31'd0, req}, 32'd1);
        chk("rm_addr", addr, 32'h0);
        tick();
        mvalid = 1'b0;
        #1;
        chk("rm_ign_vld", {31'd0, vld}, 32'd0);
        mvalid = 1'b1;
        mdata  = 32'h0070_0693;
        tick();
        mvalid = 1'b0;
        #1;
        chk("rm_fill_pc", pc, 32'h0);
        chk("rm_fill_ir", ir, 32'h0070_0693);

        // Redirect to the top word; PC and NPC wrap
        take   = 1'b1;
        target = 32'hFFFF_FFFF;
        tick();
        take = 1'b0;
        fetch_word(32'hFFFF_FFFC, 32'h0080_0713);
        #1;
        chk("wrap_addr", addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage at the front of the 5-stage pipeline, and the consumer of the execute stage's redirect (take-branch flag plus target PC).
- Keeps the architectural fetch PC and issues single-outstanding requests to instruction memory.
- Buffers one returned instruction for decode under an if/id stall handshake.
- On redirect, squashes the wrong-path instruction, including any in-flight memory response.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
NOP_INST, 32'h0000_0013, IR value presented when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  system clock
rst  in  1  system reset, synchronous, active-high
ex_take_branch_in  in  1  redirect request from execute, already qualified by valid_inst
ex_target_PC_in  in  32  redirect target
id_stall_in  in  1  decode cannot accept this cycle
Imem2proc_valid  in  1  response valid, one-cycle pulse
Imem2proc_data  in  32  instruction word, meaningful only with valid
proc2Imem_req  out  1  request strobe, one cycle per request
proc2Imem_addr  out  32  request address, word aligned
if_PC_out  out  32  PC of buffered instruction
if_NPC_out  out  32  if_PC_out + 4
if_IR_out  out  32  buffered instruction, or NOP_INST when invalid
if_valid_inst_out  out  1  buffer holds a valid instruction

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state (all registered):
  - fetch_pc = RESET_PC; state = S_REQ.
  - buf_valid = 0; if_IR_out = NOP_INST; if_PC_out = RESET_PC; if_NPC_out = RESET_PC + 4.
  - proc2Imem_req = 0 during reset cycle.
  - Reset mid-request takes effect identically; the in-flight response is ignored because state is S_REQ.
- Memory contract:
  - At most one outstanding request.
  - Response arrives 1 or more cycles after the request strobe.
  - Imem2proc_valid is ignored in S_REQ.
- consume = buf_valid & ~id_stall_in.
- FSM states: S_REQ, S_WAIT, S_FLUSH.
- S_REQ:
  - proc2Imem_req = ~ex_take_branch_in & (~buf_valid | consume).
  - proc2Imem_addr = fetch_pc (combinational).
  - If the request is issued, go to S_WAIT; otherwise stay.
  - Invariant: the buffer is empty or draining when the response arrives, so a response is never dropped for lack of space.
- S_WAIT, on Imem2proc_valid with no redirect:
  - buf_valid <= 1; if_IR_out <= data; if_PC_out <= fetch_pc; if_NPC_out <= fetch_pc + 4.
  - fetch_pc <= fetch_pc + 4 (wraps modulo 2^32).
  - Go to S_REQ.
  - Latency: request in cycle N, response in N+k, instruction visible in N+k+1.
  - Next request no earlier than N+k+1; zero-stall throughput is 1 instruction per (k+1) cycles.
- S_FLUSH:
  - Waits for the stale response, discards it, then goes to S_REQ.
  - No request is issued in S_FLUSH.
- Buffer:
  - When consume occurs and no fill happens that cycle: buf_valid <= 0, if_IR_out <= NOP_INST.
  - if_PC_out and if_NPC_out hold their values.
  - While buf_valid & id_stall_in, all if_* outputs are held stable.
- Redirect (ex_take_branch_in = 1) has highest priority over stall, fill and request:
  - fetch_pc <= {ex_target_PC_in[31:2], 2'b00}.
  - buf_valid <= 0; if_IR_out <= NOP_INST.
  - S_REQ: stay in S_REQ; no request this cycle; the new address is requested next cycle.
  - S_WAIT without response this cycle: go to S_FLUSH.
  - S_WAIT with response the same cycle: drop the response, go to S_REQ.
  - S_FLUSH: update fetch_pc, stay in S_FLUSH; if the stale response arrives the same cycle, go to S_REQ.
- Redirect while decode is stalled still squashes the buffer.
- Back-to-back redirects: the last one wins.
- No other arithmetic beyond 32-bit +4.

Test Plan:
- Reset then 1-cycle memory returning 0x00A00093 at 0x0 → req with addr 0x0 in cycle 1; cycle 3 shows valid=1, IR=0x00A00093, PC=0x0, NPC=0x4; next req has addr 0x4.
- Straight-line fetch of 4 words with no stall → PCs 0x0, 0x4, 0x8, 0xC, each valid for exactly one cycle; req strobes every 2 cycles.
- Buffered instruction at PC 0x8 with id_stall_in held high 3 cycles → outputs stable for 3 cycles, no new req; req issues in the cycle stall drops.
- Redirect to 0x104 in S_WAIT, stale response 2 cycles later → stale word never appears on IR; state goes S_FLUSH then S_REQ; next req addr is 0x104 (bits [1:0] cleared); first valid PC is 0x104.
- Redirect to 0x200 coinciding with a response → response dropped, valid=0, IR=NOP_INST; next cycle req addr is 0x200.
- Redirect while buffer is valid and stalled → valid=0, IR=0x00000013 the next cycle; fetch resumes at the target.
- Reset asserted during S_WAIT, response arriving after reset → response ignored; req issued with addr RESET_PC.
